// File: rtl/stack_cpu_core.sv
// Stack-machine core: fetch/decode FSM over a LIFO register stack, one memory port.
// One state per cycle except memory waits; mem_req is held until mem_ready, then the next access may follow back-to-back.
module stack_cpu_core #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [DATA_W-1:0]       mem_wdata,
   input  logic [DATA_W-1:0]       mem_rdata,
   input  logic                    mem_ready,
   output logic                    halted,
   output logic [1:0]              err,
   output logic [DATA_W-1:0]       tos,
   output logic [$clog2(DEPTH):0]  sp_count,
   output logic [ADDR_W-1:0]       pc_out
);

   localparam int IW = $clog2(DEPTH);
   localparam int SW = IW + 1;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_NOT  = 3'b011;
   localparam logic [2:0] OP_PUSH = 3'b100;
   localparam logic [2:0] OP_POP  = 3'b101;
   localparam logic [2:0] OP_JMP  = 3'b110;

   localparam logic [1:0] ERR_UNDER = 2'b01;
   localparam logic [1:0] ERR_OVER  = 2'b10;

   typedef enum logic [2:0] {
      FETCH, DECODE, POP_A, EXEC, MEM_RD, MEM_WR, HALT, ERROR
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] ir;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic [DATA_W-1:0] stk [DEPTH];
   logic [SW-1:0]     sp;

   logic [2:0]        opcode;
   logic [ADDR_W-1:0] iaddr;
   logic [SW-1:0]     sp_m1;
   logic [DATA_W-1:0] top;
   logic              empty;
   logic              full;
   logic [DATA_W-1:0] alu;

   assign opcode   = ir[DATA_W-1 -: 3];
   assign iaddr    = ir[ADDR_W-1:0];
   assign sp_m1    = sp - SW'(1);
   assign top      = stk[sp_m1[IW-1:0]];
   assign empty    = (sp == '0);
   assign full     = (sp == SW'(DEPTH));
   assign tos      = empty ? '0 : top;
   assign sp_count = sp;
   assign pc_out   = pc;

   // A is the older operand, B the newer one
   always_comb begin
      alu = ~a;
      case (opcode)
         OP_ADD:  alu = a + b;
         OP_SUB:  alu = a - b;
         OP_AND:  alu = a & b;
         default: alu = ~a;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= FETCH;
         pc        <= '0;
         ir        <= '0;
         a         <= '0;
         b         <= '0;
         sp        <= '0;
         err       <= '0;
         halted    <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
      end else begin
         case (state)
            FETCH: begin
               // first cycle after reset has no request yet, so raise it here
               if (mem_req && mem_ready) begin
                  ir      <= mem_rdata;
                  pc      <= pc + ADDR_W'(1);
                  mem_req <= 1'b0;
                  state   <= DECODE;
               end else if (!mem_req) begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= pc;
               end
            end
            DECODE: begin
               case (opcode)
                  OP_ADD, OP_SUB, OP_AND: begin
                     if (sp < SW'(2)) begin
                        err    <= ERR_UNDER;
                        halted <= 1'b1;
                        state  <= ERROR;
                     end else begin
                        b     <= top;
                        sp    <= sp_m1;
                        state <= POP_A;
                     end
                  end
                  OP_NOT: begin
                     if (empty) begin
                        err    <= ERR_UNDER;
                        halted <= 1'b1;
                        state  <= ERROR;
                     end else begin
                        a     <= top;
                        sp    <= sp_m1;
                        state <= EXEC;
                     end
                  end
                  OP_PUSH: begin
                     if (full) begin
                        err    <= ERR_OVER;
                        halted <= 1'b1;
                        state  <= ERROR;
                     end else begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= iaddr;
                        state    <= MEM_RD;
                     end
                  end
                  OP_POP: begin
                     if (empty) begin
                        err    <= ERR_UNDER;
                        halted <= 1'b1;
                        state  <= ERROR;
                     end else begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= iaddr;
                        mem_wdata <= top;
                        state     <= MEM_WR;
                     end
                  end
                  OP_JMP: begin
                     pc <= iaddr;
                     // pc already points past this instruction, so pc-1 is its own address
                     if (iaddr == pc - ADDR_W'(1)) begin
                        halted <= 1'b1;
                        state  <= HALT;
                     end else begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= iaddr;
                        state    <= FETCH;
                     end
                  end
                  default: begin
                     if (empty) begin
                        err    <= ERR_UNDER;
                        halted <= 1'b1;
                        state  <= ERROR;
                     end else begin
                        if (top == '0) begin
                           pc       <= iaddr;
                           mem_addr <= iaddr;
                        end else begin
                           mem_addr <= pc;
                        end
                        mem_req <= 1'b1;
                        mem_we  <= 1'b0;
                        state   <= FETCH;
                     end
                  end
               endcase
            end
            POP_A: begin
               a     <= top;
               sp    <= sp_m1;
               state <= EXEC;
            end
            EXEC: begin
               stk[sp[IW-1:0]] <= alu;
               sp              <= sp + SW'(1);
               mem_req         <= 1'b1;
               mem_we          <= 1'b0;
               mem_addr        <= pc;
               state           <= FETCH;
            end
            MEM_RD: begin
               if (mem_req && mem_ready) begin
                  stk[sp[IW-1:0]] <= mem_rdata;
                  sp              <= sp + SW'(1);
                  mem_we          <= 1'b0;
                  mem_addr        <= pc;
                  state           <= FETCH;
               end
            end
            MEM_WR: begin
               if (mem_req && mem_ready) begin
                  sp       <= sp_m1;
                  mem_we   <= 1'b0;
                  mem_addr <= pc;
                  state    <= FETCH;
               end
            end
            HALT, ERROR: begin
            end
            default: state <= ERROR;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_cpu_core.sv
// Bench for stack_cpu_core: an instruction-level reference model predicts every bus
// transaction and the final architectural state; a bus monitor checks them as they occur.
module tb_stack_cpu_core;

   localparam int DW    = 8;
   localparam int AW    = 5;
   localparam int DEPTH = 8;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_NOT  = 3'b011;
   localparam logic [2:0] OP_PUSH = 3'b100;
   localparam logic [2:0] OP_POP  = 3'b101;
   localparam logic [2:0] OP_JMP  = 3'b110;
   localparam logic [2:0] OP_JZ   = 3'b111;

   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic                    mem_req;
   logic                    mem_we;
   logic [AW-1:0]           mem_addr;
   logic [DW-1:0]           mem_wdata;
   logic [DW-1:0]           mem_rdata = '0;
   logic                    mem_ready = 1'b0;
   logic                    halted;
   logic [1:0]              err;
   logic [DW-1:0]           tos;
   logic [$clog2(DEPTH):0]  sp_count;
   logic [AW-1:0]           pc_out;

   stack_cpu_core #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .halted(halted), .err(err), .tos(tos), .sp_count(sp_count), .pc_out(pc_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } txn_t;

   txn_t          exp_q[$];
   int            n_checks = 0;
   int            n_fail   = 0;
   int            ready_pct = 100;
   logic [DW-1:0] mem  [32];
   logic [DW-1:0] rmem [32];

   bit            m_done;
   logic [1:0]    m_err;
   int            m_sp;
   logic [DW-1:0] m_tos;
   logic [AW-1:0] m_pc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic txn_t mk(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
      txn_t t;
      t.we = we; t.addr = addr; t.wdata = wd;
      return t;
   endfunction

   function automatic logic [DW-1:0] ins(input logic [2:0] op, input int ad);
      logic [AW-1:0] a5;
      a5 = AW'(ad);
      return {op, a5};
   endfunction

   // Memory: ready decided mid-cycle, writes committed just before the edge that completes them
   always @(negedge clk) begin
      mem_ready = ($urandom_range(0, 99) < ready_pct);
      mem_rdata = mem[mem_addr];
      #4;
      if (rst && mem_req && mem_ready && mem_we) mem[mem_addr] = mem_wdata;
   end

   always @(negedge clk) begin : monitor
      txn_t got;
      txn_t e;
      #4;
      if (rst && mem_req && mem_ready) begin
         got = mk(mem_we, mem_addr, mem_we ? mem_wdata : '0);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_txn: actual=%0h required=none (t=%0t)", got, $time);
         end else begin
            e = exp_q.pop_front();
            check("bus_txn", 32'(got), 32'(e));
         end
      end
   end

   // Instruction-level interpreter over a private copy of memory
   task automatic run_model();
      logic [DW-1:0] st[$];
      logic [AW-1:0] pc, cur, ad;
      logic [DW-1:0] ir, a, b;
      logic [2:0]    op;
      exp_q.delete();
      for (int i = 0; i < 32; i++) rmem[i] = mem[i];
      pc = '0; m_done = 0; m_err = 2'b00;
      for (int step = 0; step < 100 && !m_done; step++) begin
         exp_q.push_back(mk(1'b0, pc, '0));
         cur = pc;
         ir  = rmem[pc];
         pc  = pc + 1'b1;
         op  = ir[7:5];
         ad  = ir[4:0];
         case (op)
            OP_ADD, OP_SUB, OP_AND: begin
               if (st.size() < 2) begin m_err = 2'b01; m_done = 1; end
               else begin
                  b = st.pop_back();
                  a = st.pop_back();
                  if (op == OP_ADD)      st.push_back(a + b);
                  else if (op == OP_SUB) st.push_back(a - b);
                  else                   st.push_back(a & b);
               end
            end
            OP_NOT: begin
               if (st.size() == 0) begin m_err = 2'b01; m_done = 1; end
               else begin a = st.pop_back(); st.push_back(~a); end
            end
            OP_PUSH: begin
               if (st.size() == DEPTH) begin m_err = 2'b10; m_done = 1; end
               else begin exp_q.push_back(mk(1'b0, ad, '0)); st.push_back(rmem[ad]); end
            end
            OP_POP: begin
               if (st.size() == 0) begin m_err = 2'b01; m_done = 1; end
               else begin exp_q.push_back(mk(1'b1, ad, st[$])); rmem[ad] = st.pop_back(); end
            end
            OP_JMP: begin
               if (ad == cur) m_done = 1;
               pc = ad;
            end
            default: begin
               if (st.size() == 0) begin m_err = 2'b01; m_done = 1; end
               else if (st[$] == '0) pc = ad;
            end
         endcase
      end
      m_sp  = st.size();
      m_tos = (st.size() != 0) ? st[$] : '0;
      m_pc  = pc;
   endtask

   task automatic start(input int pct);
      run_model();
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("rst_mem_req", 32'(mem_req), 0);
      check("rst_mem_we", 32'(mem_we), 0);
      check("rst_halted", 32'(halted), 0);
      check("rst_err", 32'(err), 0);
      check("rst_sp", 32'(sp_count), 0);
      check("rst_tos", 32'(tos), 0);
      check("rst_pc", 32'(pc_out), 0);
      ready_pct = pct;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("first_req", 32'(mem_req), 1);
      check("first_addr", 32'(mem_addr), 0);
   endtask

   task automatic run_test(input int pct, input int stall);
      bit reached;
      start(pct);
      if (stall > 0) begin
         ready_pct = 0;
         for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            check("stall_req", 32'(mem_req), 1);
            check("stall_addr", 32'(mem_addr), 0);
            check("stall_pc", 32'(pc_out), 0);
         end
         ready_pct = 100;
         @(posedge clk); #1;
         check("stall_pc_after", 32'(pc_out), 1);
         ready_pct = pct;
      end
      reached = 0;
      for (int c = 0; c < 3000 && !reached; c++) begin
         @(posedge clk); #1;
         if (m_done ? halted : (exp_q.size() == 0)) reached = 1;
      end
      check("run_done", 32'(reached), 1);
      if (m_done) begin
         check("end_halted", 32'(halted), 1);
         check("end_err", 32'(err), 32'(m_err));
         check("end_sp", 32'(sp_count), 32'(m_sp));
         check("end_tos", 32'(tos), 32'(m_tos));
         check("end_pc", 32'(pc_out), 32'(m_pc));
         check("end_queue", 32'(exp_q.size()), 0);
      end else begin
         rst = 1'b0;
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 32; i++) mem[i] = '0;
   endtask

   task automatic load_arith(input logic [2:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y);
      clear_mem();
      mem[0] = ins(OP_PUSH, 20);
      mem[1] = ins(OP_PUSH, 21);
      mem[2] = ins(op, 0);
      mem[3] = ins(OP_POP, 22);
      mem[4] = ins(OP_JMP, 4);
      mem[20] = x;
      mem[21] = y;
   endtask

   task automatic gen_random();
      int r;
      for (int i = 0; i < 15; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2, 3: mem[i] = ins(OP_PUSH, $urandom_range(16, 31));
            4:          mem[i] = ins(OP_POP, $urandom_range(16, 31));
            5:          mem[i] = ins(OP_ADD, $urandom_range(0, 31));
            6:          mem[i] = ins(OP_SUB, $urandom_range(0, 31));
            7:          mem[i] = ins(($urandom_range(0, 1) != 0) ? OP_AND : OP_NOT, $urandom_range(0, 31));
            8:          mem[i] = ins(OP_JZ, $urandom_range(0, 15));
            default:    mem[i] = ins(OP_JMP, $urandom_range(0, 15));
         endcase
      end
      mem[15] = ins(OP_JMP, 15);
      for (int i = 16; i < 32; i++)
         mem[i] = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
   endtask

   initial begin
      bit seen;

      load_arith(OP_ADD, 8'h05, 8'h03);
      run_test(100, 0);
      check("add_result", 32'(mem[22]), 32'h08);
      check("add_err", 32'(err), 0);
      check("add_sp", 32'(sp_count), 0);

      load_arith(OP_SUB, 8'h03, 8'h05);
      run_test(100, 0);
      check("sub_result", 32'(mem[22]), 32'hFE);

      load_arith(OP_ADD, 8'h05, 8'h03);
      run_test(100, 3);
      check("stall_result", 32'(mem[22]), 32'h08);

      clear_mem();
      for (int i = 0; i < 9; i++) begin
         mem[i]      = ins(OP_PUSH, 16 + i);
         mem[16 + i] = DW'(8'h30 + i);
      end
      run_test(100, 0);
      check("ovf_err", 32'(err), 2);
      check("ovf_sp", 32'(sp_count), 8);
      check("ovf_halted", 32'(halted), 1);

      clear_mem();
      mem[0] = ins(OP_ADD, 0);
      run_test(60, 0);
      check("unf_err", 32'(err), 1);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("unf_no_req", 32'(mem_req), 0);
      end

      clear_mem();
      mem[0] = ins(OP_PUSH, 20);
      mem[1] = ins(OP_JZ, 8);
      mem[2] = ins(OP_JMP, 2);
      mem[8] = ins(OP_JMP, 8);
      run_test(70, 0);
      check("jz_taken_pc", 32'(pc_out), 8);
      check("jz_taken_sp", 32'(sp_count), 1);
      mem[20] = 8'h01;
      run_test(70, 0);
      check("jz_fall_pc", 32'(pc_out), 2);
      check("jz_fall_tos", 32'(tos), 1);

      // reset lands while a write is being offered with mem_ready high
      clear_mem();
      mem[0]  = ins(OP_PUSH, 20);
      mem[1]  = ins(OP_POP, 22);
      mem[2]  = ins(OP_JMP, 2);
      mem[20] = 8'h5C;
      mem[22] = 8'hAA;
      start(100);
      seen = 0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(posedge clk); #1;
         if (mem_req && mem_we) seen = 1;
      end
      check("wr_reached", 32'(seen), 1);
      @(negedge clk); #2;
      rst = 1'b0;
      #1;
      check("midwr_req", 32'(mem_req), 0);
      check("midwr_pc", 32'(pc_out), 0);
      check("midwr_sp", 32'(sp_count), 0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      check("midwr_nowrite", 32'(mem[22]), 32'hAA);

      for (int t = 0; t < 30; t++) begin
         clear_mem();
         gen_random();
         run_test((t % 2 == 0) ? 100 : 50, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
